ball_motion_unit: RTL and testbench



---
 rtl/ball_motion_unit.sv | 190 +++++++++++++++++++
 tb/tb_ball_motion_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_unit.sv
// Frame-rate ball motion generator: absolute position/velocity, wall and paddle
// bounces, bottom-edge miss with delayed re-serve, and a registered ball pixel.
module ball_motion_unit #(
    parameter int COORD_W      = 9,
    parameter int H_DISPLAY    = 256,
    parameter int V_DISPLAY    = 240,
    parameter int BALL_SIZE    = 4,
    parameter int SPEED_W      = 3,
    parameter int INIT_HSPEED  = 2,
    parameter int INIT_VSPEED  = 1,
    parameter int MAX_SPEED    = 7,
    parameter int SPEEDUP_HITS = 4,
    parameter int SERVE_X      = 128,
    parameter int SERVE_Y      = 64,
    parameter int SERVE_DELAY  = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic               serve,
    input  logic               obstacle_gfx,
    output logic               ball_gfx,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               serving,
    output logic               hit,
    output logic               bounce,
    output logic               miss
);

    localparam int CW    = COORD_W + 1;
    localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
    localparam int HIT_W = (SPEEDUP_HITS < 2) ? 1 : $clog2(SPEEDUP_HITS + 1);

    localparam logic [CW-1:0]      H_LIMIT   = CW'(H_DISPLAY - BALL_SIZE);
    localparam logic [CW-1:0]      V_LIMIT   = CW'(V_DISPLAY - BALL_SIZE);
    localparam logic [COORD_W-1:0] H_LIMIT_C = COORD_W'(H_DISPLAY - BALL_SIZE);
    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(MAX_SPEED);

    typedef enum logic [1:0] {IDLE, SERVE_WAIT, MOVE} state_t;

    state_t             state;
    logic [SPEED_W-1:0] hspeed, vspeed;
    logic               hdir, vdir;      // hdir 1 = right, vdir 1 = down
    logic               serve_right;     // direction of the next serve
    logic               hit_latch;
    logic [CNT_W-1:0]   frame_cnt;
    logic [HIT_W-1:0]   hit_cnt;

    logic               frame_tick;
    logic [CW-1:0]      x_w, y_w, hs_w, vs_w, hpos_w, vpos_w;
    logic [COORD_W-1:0] x_next, y_next;
    logic               hdir_next, h_bounce, v_hit, v_bounce, v_miss;

    assign frame_tick = (hpos == '0) && (vpos == COORD_W'(V_DISPLAY));

    // Widened copies so position + speed comparisons never wrap.
    assign x_w    = {1'b0, ball_x};
    assign y_w    = {1'b0, ball_y};
    assign hs_w   = CW'(hspeed);
    assign vs_w   = CW'(vspeed);
    assign hpos_w = {1'b0, hpos};
    assign vpos_w = {1'b0, vpos};

    always_comb begin
        x_next    = ball_x;
        hdir_next = hdir;
        h_bounce  = 1'b0;
        if (hdir) begin
            if (x_w + hs_w >= H_LIMIT) begin
                x_next    = H_LIMIT_C;
                hdir_next = 1'b0;
                h_bounce  = 1'b1;
            end else begin
                x_next = ball_x + COORD_W'(hspeed);
            end
        end else if (x_w <= hs_w) begin
            x_next    = '0;
            hdir_next = 1'b1;
            h_bounce  = 1'b1;
        end else begin
            x_next = ball_x - COORD_W'(hspeed);
        end
    end

    // A paddle hit outranks wall bounce and miss on the vertical axis.
    always_comb begin
        v_hit    = hit_latch;
        v_bounce = !hit_latch && !vdir && (y_w <= vs_w);
        v_miss   = !hit_latch && vdir && (y_w + vs_w >= V_LIMIT);
        y_next   = ball_y;
        if (v_hit || v_bounce)
            y_next = (y_w <= vs_w) ? '0 : ball_y - COORD_W'(vspeed);
        else if (!v_miss)
            y_next = vdir ? ball_y + COORD_W'(vspeed) : ball_y - COORD_W'(vspeed);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            serving     <= 1'b1;
            ball_x      <= COORD_W'(SERVE_X);
            ball_y      <= COORD_W'(SERVE_Y);
            hspeed      <= SPEED_W'(INIT_HSPEED);
            vspeed      <= SPEED_W'(INIT_VSPEED);
            hdir        <= 1'b1;
            vdir        <= 1'b1;
            serve_right <= 1'b1;
            hit_latch   <= 1'b0;
            frame_cnt   <= '0;
            hit_cnt     <= '0;
            ball_gfx    <= 1'b0;
            hit         <= 1'b0;
            bounce      <= 1'b0;
            miss        <= 1'b0;
        end else begin
            hit    <= 1'b0;
            bounce <= 1'b0;
            miss   <= 1'b0;

            ball_gfx <= (state == MOVE)
                     && (hpos_w >= x_w) && (hpos_w < x_w + CW'(BALL_SIZE))
                     && (vpos_w >= y_w) && (vpos_w < y_w + CW'(BALL_SIZE));

            if (frame_tick)
                hit_latch <= 1'b0;
            else if (state == MOVE && ball_gfx && obstacle_gfx)
                hit_latch <= 1'b1;

            case (state)
                IDLE: begin
                    if (serve) begin
                        state     <= SERVE_WAIT;
                        frame_cnt <= CNT_W'(SERVE_DELAY);
                    end
                end
                SERVE_WAIT: begin
                    if (frame_tick) begin
                        if (frame_cnt == '0) begin
                            state       <= MOVE;
                            serving     <= 1'b0;
                            ball_x      <= COORD_W'(SERVE_X);
                            ball_y      <= COORD_W'(SERVE_Y);
                            hspeed      <= SPEED_W'(INIT_HSPEED);
                            vspeed      <= SPEED_W'(INIT_VSPEED);
                            hit_cnt     <= '0;
                            vdir        <= 1'b1;
                            hdir        <= serve_right;
                            serve_right <= ~serve_right;
                        end else begin
                            frame_cnt <= frame_cnt - 1'b1;
                        end
                    end
                end
                MOVE: begin
                    if (frame_tick) begin
                        if (v_miss) begin
                            miss      <= 1'b1;
                            state     <= SERVE_WAIT;
                            serving   <= 1'b1;
                            frame_cnt <= CNT_W'(SERVE_DELAY);
                        end else begin
                            ball_x <= x_next;
                            hdir   <= hdir_next;
                            ball_y <= y_next;
                            bounce <= h_bounce | v_bounce;
                            hit    <= v_hit;
                            if (v_hit)
                                vdir <= 1'b0;
                            else if (v_bounce)
                                vdir <= 1'b1;
                            if (v_hit) begin
                                if (hit_cnt == HIT_W'(SPEEDUP_HITS - 1)) begin
                                    hit_cnt <= '0;
                                    hspeed  <= (hspeed >= SPD_MAX) ? SPD_MAX : hspeed + 1'b1;
                                    vspeed  <= (vspeed >= SPD_MAX) ? SPD_MAX : vspeed + 1'b1;
                                end else begin
                                    hit_cnt <= hit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_unit.sv
// Randomised frame-level stimulus for ball_motion_unit checked against an
// integer game model of the ball (position, speeds, directions, serve timer).
module tb_ball_motion_unit;

    localparam int SD   = 2;
    localparam int LIMX = 252;
    localparam int LIMY = 236;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       serve, obstacle_gfx;
    logic       ball_gfx, serving, hit, bounce, miss;
    logic [8:0] ball_x, ball_y;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 waiting to serve, 2 moving
    int mx, my, mhs, mvs, mhits, mcnt, mode;
    bit mright, mdown, mlatch, mserve_right, mgfx, ehit, ebounce, emiss;

    ball_motion_unit #(.SERVE_DELAY(SD)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .serve(serve),
        .obstacle_gfx(obstacle_gfx), .ball_gfx(ball_gfx), .ball_x(ball_x),
        .ball_y(ball_y), .serving(serving), .hit(hit), .bounce(bounce), .miss(miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mode = 0; mx = 128; my = 64; mhs = 2; mvs = 1; mhits = 0; mcnt = 0;
        mright = 1; mdown = 1; mlatch = 0; mserve_right = 1; mgfx = 0;
        ehit = 0; ebounce = 0; emiss = 0;
    endfunction

    function automatic int sat(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic void frame_move();
        int nx = mx;
        bit nr = mright, hb = 0, apply_h = 1;
        if (mright) begin
            if (mx + mhs >= LIMX) begin nx = LIMX; nr = 0; hb = 1; end
            else nx = mx + mhs;
        end else begin
            if (mx <= mhs) begin nx = 0; nr = 1; hb = 1; end
            else nx = mx - mhs;
        end
        if (mlatch) begin
            mdown = 0;
            my = (my <= mvs) ? 0 : my - mvs;
            ehit = 1;
            mhits++;
            if (mhits == 4) begin mhits = 0; mhs = sat(mhs + 1); mvs = sat(mvs + 1); end
        end else if (!mdown && my <= mvs) begin
            my = 0; mdown = 1; ebounce = 1;
        end else if (mdown && my + mvs >= LIMY) begin
            emiss = 1; mode = 1; mcnt = SD; apply_h = 0;
        end else begin
            my = mdown ? my + mvs : my - mvs;
        end
        if (apply_h) begin
            mx = nx; mright = nr;
            if (hb) ebounce = 1;
        end
    endfunction

    // Advance the model across one rising edge using the inputs held there.
    function automatic void model_edge();
        int hp = int'(hpos), vp = int'(vpos);
        bit tick, ng;
        if (reset) begin model_reset(); return; end
        tick = (hp == 0) && (vp == 240);
        ng = (mode == 2) && hp >= mx && hp < mx + 4 && vp >= my && vp < my + 4;
        ehit = 0; ebounce = 0; emiss = 0;
        if (!tick && mode == 2 && mgfx && obstacle_gfx) mlatch = 1;
        case (mode)
            0: if (serve) begin mode = 1; mcnt = SD; end
            1: if (tick) begin
                if (mcnt == 0) begin
                    mode = 2; mx = 128; my = 64; mhs = 2; mvs = 1; mhits = 0;
                    mdown = 1; mright = mserve_right; mserve_right = !mserve_right;
                end else mcnt--;
            end
            default: if (tick) frame_move();
        endcase
        if (tick) mlatch = 0;
        mgfx = ng;
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".ball_gfx"}, ball_gfx, mgfx);
        chk({tag, ".ball_x"}, ball_x, mx);
        chk({tag, ".ball_y"}, ball_y, my);
        chk({tag, ".serving"}, serving, mode != 2);
        chk({tag, ".hit"}, hit, ehit);
        chk({tag, ".bounce"}, bounce, ebounce);
        chk({tag, ".miss"}, miss, emiss);
    endtask

    task automatic do_tick();
        hpos = 9'd0; vpos = 9'd240; obstacle_gfx = 1'b0;
        step("tick");
        hpos = 9'd511; vpos = 9'd511;
    endtask

    // Park the beam at an offset from the ball's corner for two clocks.
    task automatic probe(input int dx, input int dy, input bit ob);
        hpos = 9'(mx + dx); vpos = 9'(my + dy); obstacle_gfx = ob;
        step("probe");
        step("probe2");
        obstacle_gfx = 1'b0; hpos = 9'd511; vpos = 9'd511;
    endtask

    task automatic random_frames(input int n);
        for (int f = 0; f < n; f++) begin
            if (mode == 2 && mdown && my + mvs >= LIMY && ($urandom % 4) != 0)
                probe($urandom % 4, $urandom % 4, 1'b1);
            else
                probe($urandom_range(0, 5), $urandom_range(0, 5), ($urandom % 8) == 0);
            if ($urandom % 2) probe($urandom_range(0, 5), $urandom_range(0, 5), 1'b0);
            do_tick();
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b1; serve = 1'b0; obstacle_gfx = 1'b0;
        hpos = 9'd511; vpos = 9'd511;
        step("reset");
        step("reset");
        chk("rst_ball_x", ball_x, 128);
        chk("rst_ball_y", ball_y, 64);
        chk("rst_serving", serving, 1);
        chk("rst_gfx", ball_gfx, 0);
        reset = 1'b0;

        do_tick();
        do_tick();
        chk("idle_no_serve", serving, 1);

        serve = 1'b1;
        step("serve");
        do_tick();
        do_tick();
        chk("serve_wait2", serving, 1);
        do_tick();
        chk("serve_drop", serving, 0);
        chk("serve_x", ball_x, 128);
        chk("serve_y", ball_y, 64);
        do_tick();
        chk("first_move_x", ball_x, 130);
        chk("first_move_y", ball_y, 65);

        random_frames(1500);

        for (int i = 0; i < 10 && mode != 2; i++) do_tick();
        chk("pre_reset_moving", serving, 0);
        hpos = 9'd100; vpos = 9'd50; reset = 1'b1;
        step("mid_reset");
        chk("mid_reset_gfx", ball_gfx, 0);
        chk("mid_reset_x", ball_x, 128);
        chk("mid_reset_y", ball_y, 64);
        chk("mid_reset_serving", serving, 1);
        reset = 1'b0; hpos = 9'd511; vpos = 9'd511;

        random_frames(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
